multdiv_sequencer: RTL and testbench

Iterative signed multiply/divide unit with its own control FSM, sitting beside the ALU in the execute stage of the 5-stage pipeline.
- Accepts a one-cycle start from execute control (R-type ALU op mul/div), then runs a 32-iteration shift-add or restoring-divide sequence.
- Holds fetch/decode/execute latches and the PC via stall until the result is ready.
- Presents the result for one cycle so the execute/memory latch captures it in place of the ALU output.

---
 rtl/multdiv_pkg.sv | 12 +
 rtl/multdiv_step.sv | 26 ++
 rtl/multdiv_sequencer.sv | 113 +++++++++++
 tb/tb_multdiv_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared FSM state encoding and execute-stage ALU opcodes for the mul/div unit.
package multdiv_pkg;
  localparam int ALU_OP_WIDTH = 5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MUL = 5'b00110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_DIV = 5'b00111;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MULT = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_t;
endpackage

// File: rtl/multdiv_step.sv
// multdiv_step: one shift-add (multiply) or restore-subtract (divide) iteration.
module multdiv_step #(
  parameter int W = 32
) (
  input  logic           i_div,
  input  logic [2*W-1:0] i_acc,
  input  logic [W-1:0]   i_opr,
  input  logic [2*W-1:0] i_arg,
  output logic [2*W-1:0] o_acc,
  output logic [W-1:0]   o_opr,
  output logic [2*W-1:0] o_arg,
  output logic           o_borrow
);
  logic [W:0]   w_rem_s;
  logic [W+1:0] w_diff;
  // Divide keeps the partial remainder in the low W+1 bits of the accumulator.
  assign w_rem_s  = {i_acc[W-1:0], i_opr[W-1]};
  assign w_diff   = {1'b0, w_rem_s} - {2'b00, i_arg[W-1:0]};
  assign o_borrow = i_div & w_diff[W+1];
  always_comb begin
    o_acc = i_div ? (2*W)'(w_diff[W+1] ? w_rem_s : w_diff[W:0])
                  : (i_opr[0] ? i_acc + i_arg : i_acc);
    o_opr = i_div ? {i_opr[W-2:0], 1'b0} : i_opr >> 1;
    o_arg = i_div ? i_arg : i_arg << 1;
  end
endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: iterative signed mul/div with pipeline stall control.
// Define MULTDIV_EARLY_TERM_EN to finish a multiply once the remaining multiplier is zero.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_mult,
  input  logic                  start_div,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  flush,
  output logic                  stall,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic                  exception
);
  localparam int W = DATA_WIDTH;
  state_t r_state, w_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2*W-1:0] r_acc, r_arg, w_acc_n, w_arg_n, w_prod;
  logic [W-1:0] r_opr, w_opr_n, w_opr_x, w_quot, w_mag_a, w_mag_b, r_result, w_fin_res;
  logic r_sign, r_exc, w_borrow, w_start, w_last, w_mult_end, w_fin_exc, w_prod_ovf;

  assign w_start = (start_mult | start_div) & ~flush;
  assign w_mag_a = op_a[W-1] ? -op_a : op_a;
  assign w_mag_b = op_b[W-1] ? -op_b : op_b;
  assign w_last  = r_cnt == CNT_WIDTH'(W - 1);

  multdiv_step #(.W(W)) u_step (
    .i_div   (r_state == DIV),
    .i_acc   (r_acc),
    .i_opr   (r_opr),
    .i_arg   (r_arg),
    .o_acc   (w_acc_n),
    .o_opr   (w_opr_n),
    .o_arg   (w_arg_n),
    .o_borrow(w_borrow)
  );

  // The quotient bit shifted in is the inverse of the subtract borrow.
  assign w_opr_x = (r_state == DIV) ? {w_opr_n[W-1:1], ~w_borrow} : w_opr_n;
`ifdef MULTDIV_EARLY_TERM_EN
  assign w_mult_end = w_last | ~|w_opr_x;
`else
  assign w_mult_end = w_last;
`endif

  assign w_prod     = r_sign ? -w_acc_n : w_acc_n;
  assign w_prod_ovf = ~(&w_prod[2*W-1:W-1]) & (|w_prod[2*W-1:W-1]);
  assign w_quot     = r_sign ? -w_opr_x : w_opr_x;
  // Completion out of IDLE only happens for divide-by-zero.
  assign w_fin_res  = (r_state == MULT) ? w_prod[W-1:0] : (r_state == DIV) ? w_quot : '0;
  assign w_fin_exc  = (r_state == MULT) ? w_prod_ovf : (r_state == DIV) ? ~r_sign & w_opr_x[W-1] : 1'b1;

  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: w_next = flush ? IDLE : start_mult ? MULT : start_div ? ((op_b == '0) ? DONE : DIV) : IDLE;
      MULT: w_next = flush ? IDLE : w_mult_end ? DONE : MULT;
      DIV:  w_next = flush ? IDLE : w_last ? DONE : DIV;
      DONE: w_next = IDLE;
    endcase
  end

  always_comb begin
    stall        = ((r_state == IDLE) & (start_mult | start_div) & ~flush) | (r_state == MULT) | (r_state == DIV);
    busy         = r_state != IDLE;
    result_valid = (r_state == DONE) & ~flush;
    exception    = (r_state == DONE) & ~flush & r_exc;
  end

  assign result = r_result;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opr    <= '0;
      r_arg    <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else begin
      if (r_state == IDLE && w_start) begin
        r_cnt  <= '0;
        r_acc  <= '0;
        r_sign <= op_a[W-1] ^ op_b[W-1];
        r_opr  <= start_mult ? w_mag_b : w_mag_a;
        r_arg  <= (2*W)'(start_mult ? w_mag_a : w_mag_b);
      end else if (r_state == MULT || r_state == DIV) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_acc_n;
        r_opr <= w_opr_x;
        r_arg <= w_arg_n;
      end else begin
        r_cnt <= '0;
      end
      if (w_next == DONE && r_state != DONE) begin
        r_result <= w_fin_res;
        r_exc    <= w_fin_exc;
      end
    end
  end
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed vectors with a queue-based scoreboard and negedge monitor.
module tb_multdiv_sequencer;
`ifdef MULTDIV_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, start_mult = 1'b0, start_div = 1'b0, flush = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, result;
  logic stall, busy, result_valid, exception;
  int cyc = 0, stall_total = 0, checks = 0, errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          issue;
    int          lat;
    int          stall_base;
  } exp_t;
  exp_t q[$];

  multdiv_sequencer dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall), .busy(busy),
    .result(result), .result_valid(result_valid), .exception(exception)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endfunction

  initial forever begin
    @(negedge clock);
    if (stall) stall_total++;
    if (result_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result %h with no pending operation (cycle %0d)", result, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.res);
        chk("exception", 32'(exception), 32'(e.exc));
        chk("latency", 32'(cyc - e.issue), 32'(e.lat));
        chk("stall_cycles", 32'(stall_total - e.stall_base), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic sm, input logic sd, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] res, input logic exc, input int lf, input int le);
    exp_t e;
    @(posedge clock); #1;
    start_mult = sm; start_div = sd; op_a = a; op_b = b;
    if (push) begin
      e.res = res; e.exc = exc; e.issue = cyc; e.lat = ET ? le : lf; e.stall_base = stall_total;
      q.push_back(e);
    end
    @(posedge clock); #1;
    start_mult = 1'b0; start_div = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clock);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d operations still pending at cycle %0d", q.size(), cyc);
      q.delete();
    end
  endtask

  task automatic run(input logic sm, input logic sd, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic exc, input int lf, input int le);
    issue(sm, sd, a, b, 1'b1, res, exc, lf, le);
    wait_empty();
  endtask

  initial begin
    repeat (2) @(posedge clock); #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result", result, 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_exception", 32'(exception), 0);
    reset = 1'b0;

    run(1, 0, 32'd6, -32'sd7, 32'hFFFFFFD6, 0, 33, 4);
    run(0, 1, -32'sd100, 32'd7, 32'hFFFFFFF2, 0, 33, 33);
    run(0, 1, 32'd5, 32'd0, 32'h0, 1, 1, 1);
    run(1, 0, 32'h00010000, 32'h00010000, 32'h0, 1, 33, 18);
    run(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 33, 33);
    run(0, 1, -32'sd7, 32'd2, 32'hFFFFFFFD, 0, 33, 33);
    run(0, 1, 32'h80000000, 32'd1, 32'h80000000, 0, 33, 33);
    run(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 0, 33, 2);
    run(1, 0, 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1, 33, 3);
    run(1, 0, 32'hFFFF0000, 32'h00008000, 32'h80000000, 0, 33, 17);
    run(1, 0, 32'd5, 32'd7, 32'd35, 0, 33, 4);
    run(1, 1, 32'd3, 32'd4, 32'd12, 0, 33, 4);
    run(1, 0, 32'd0, 32'd9, 32'd0, 0, 33, 5);

    // flush at cycle 10 of a long multiply: aborted, then a fresh multiply
    issue(1, 0, 32'd3, 32'h7FFFFFFF, 1'b0, 0, 0, 0, 0);
    repeat (9) @(posedge clock); #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 0);
    chk("flush_stall", 32'(stall), 0);
    repeat (40) @(posedge clock);
    run(1, 0, 32'd3, 32'd4, 32'd12, 0, 33, 4);

    // reset at cycle 10 of a long multiply
    issue(1, 0, 32'd3, 32'h7FFFFFFF, 1'b0, 0, 0, 0, 0);
    repeat (9) @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("areset_busy", 32'(busy), 0);
    chk("areset_result", result, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    chk("areset_busy_next", 32'(busy), 0);
    repeat (40) @(posedge clock);
    run(1, 0, 32'd3, 32'd4, 32'd12, 0, 33, 4);

    // start coincident with flush in IDLE is dropped
    @(posedge clock); #1;
    start_mult = 1'b1; op_a = 32'd9; op_b = 32'd9; flush = 1'b1;
    #1;
    chk("flush_start_stall", 32'(stall), 0);
    @(posedge clock); #1;
    start_mult = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 0);
    repeat (40) @(posedge clock);

    // start_div mid-multiply is ignored; exactly one result appears
    issue(1, 0, -32'sd3, 32'h01000000, 1'b1, 32'hFD000000, 0, 33, 26);
    repeat (3) @(posedge clock); #1;
    start_div = 1'b1; op_a = 32'd1; op_b = 32'd0;
    @(posedge clock); #1;
    start_div = 1'b0;
    wait_empty();
    repeat (40) @(posedge clock);
    chk("idle_after_ignored_start", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
